// File: rtl/txrx_pkg.sv
// Shared types for the transmit/receive link scheduler.
//   state_t  : scheduler FSM states
//   result_t : per-transfer verdict {pass, fail, len}
//   DEF_MIN_RX / DEF_MAX_RX : default receive burst window
package txrx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TX   = 2'd1,
    ST_RX   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam int DEF_MIN_RX = 2;
  localparam int DEF_MAX_RX = 3;

  // Length field is wide enough for any practical MAX_RX; the top narrows it
  // to its own counter width on the way out.
  localparam int LEN_W = 8;

  typedef struct packed {
    logic             pass;
    logic             fail;
    logic [LEN_W-1:0] len;
  } result_t;

endpackage

// File: rtl/txrx_link_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i : request vector
//   ptr_i : index with highest priority this round
//   gnt_o : one-hot grant (all zero when no request)
//   idx_o : binary index of the granted requester
module rr_arbiter
  import txrx_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [PTR_W-1:0] idx_o
);

  logic             found;
  int               cand;
  logic [PTR_W-1:0] cidx;

  // Walk from the pointer upwards, wrapping once; first set bit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    cidx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = int'(ptr_i) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      cidx = cand[PTR_W-1:0];
      if (!found && req_i[cidx]) begin
        found       = 1'b1;
        gnt_o[cidx] = 1'b1;
        idx_o       = cidx;
      end
    end
  end

endmodule

// File: rtl/txrx_link_sched.sv
// Round-robin scheduler sharing one transmit/receive link among NREQ agents.
// Each grant emits a one-cycle tx_o strobe, then measures the consecutive
// rx_i-high burst that follows and reports pass/fail plus its length.
//   clk, rst_n   : clock, asynchronous active-low reset
//   req_i        : level requests, held until the owner's done_o
//   gnt_o        : one-hot grant, asserted from the TX cycle through RESP
//   tx_o         : transmit strobe, one cycle per transfer
//   rx_i         : receiver acknowledge
//   busy_o       : scheduler not idle
//   done_o       : one-cycle end-of-transfer pulse
//   pass_o/fail_o: verdict, valid with done_o
//   burst_len_o  : measured burst length, valid with done_o
module txrx_link_sched
  import txrx_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int MIN_RX = DEF_MIN_RX,
  parameter int MAX_RX = DEF_MAX_RX,
  parameter int CNT_W  = $clog2(MAX_RX + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic             tx_o,
  input  logic             rx_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic [CNT_W-1:0] burst_len_o
);

  localparam int PTR_W = $clog2(NREQ);

  state_t           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [PTR_W-1:0] idx_q, idx_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  result_t          res_q, res_d;

  logic [NREQ-1:0]  arb_gnt;
  logic [PTR_W-1:0] arb_idx;
  logic [CNT_W-1:0] cnt_inc;
  logic             pass_v;

  // Clamp the stored length into the output width.
  function automatic logic [CNT_W-1:0] sat_len(input logic [LEN_W-1:0] len);
    logic ovf;
    ovf = 1'b0;
    for (int i = CNT_W; i < LEN_W; i++) ovf = ovf | len[i];
    sat_len = ovf ? '1 : len[CNT_W-1:0];
  endfunction

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    tx_d    = 1'b0;
    done_d  = 1'b0;
    res_d   = '0;
    pass_v  = 1'b0;
    cnt_inc = cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (|req_i) begin
          state_d = ST_TX;
          gnt_d   = arb_gnt;
          idx_d   = arb_idx;
          tx_d    = 1'b1;
        end
      end
      ST_TX: begin
        cnt_d   = '0;
        state_d = ST_RX;
      end
      ST_RX: begin
        // Outputs are registered, so the verdict is loaded on the way into
        // RESP and is visible exactly while done_o is high.
        if (rx_i) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(MAX_RX)) begin
            state_d    = ST_RESP;
            done_d     = 1'b1;
            res_d.pass = 1'b1;
            res_d.len  = LEN_W'(cnt_inc);
          end
        end else begin
          pass_v     = (cnt_q >= CNT_W'(MIN_RX));
          state_d    = ST_RESP;
          done_d     = 1'b1;
          res_d.pass = pass_v;
          res_d.fail = !pass_v;
          res_d.len  = LEN_W'(cnt_q);
        end
      end
      ST_RESP: begin
        ptr_d   = (idx_q == PTR_W'(NREQ - 1)) ? '0 : idx_q + 1'b1;
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      tx_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign tx_o        = tx_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = res_q.pass;
  assign fail_o      = res_q.fail;
  assign burst_len_o = sat_len(res_q.len);

endmodule

// File: tb/tb_txrx_link_sched.sv
// Scoreboard bench for txrx_link_sched: the driver pushes the expected
// verdict of every transfer, the monitor pops and checks it on done_o.
module tb_txrx_link_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req_i = '0;
  logic       rx_i = 1'b0;
  logic [3:0] gnt_o;
  logic       tx_o, busy_o, done_o, pass_o, fail_o;
  logic [1:0] burst_len_o;

  txrx_link_sched #(.NREQ(4), .MIN_RX(2), .MAX_RX(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .tx_o        (tx_o),
    .rx_i        (rx_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .pass_o      (pass_o),
    .fail_o      (fail_o),
    .burst_len_o (burst_len_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] gnt;
    logic       pass;
    logic       fail;
    logic [1:0] len;
    int         lat;   // cycles from tx_o to done_o
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_tx = -1;
  int   tx_gap = 0;
  logic prev_tx = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (tx_o) begin
      check("tx_single_cycle", {31'd0, prev_tx}, 32'd0);
      if (last_tx >= 0) tx_gap = cyc - last_tx;
      last_tx = cyc;
    end
    prev_tx = tx_o;
    if (done_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("gnt",     {28'd0, gnt_o},       {28'd0, e.gnt});
        check("pass",    {31'd0, pass_o},      {31'd0, e.pass});
        check("fail",    {31'd0, fail_o},      {31'd0, e.fail});
        check("len",     {30'd0, burst_len_o}, {30'd0, e.len});
        check("latency", cyc - last_tx,        e.lat);
      end
    end
  end

  // One transfer: raise req, wait for tx_o, then play rx pattern bits
  // (bit 0 first) starting the cycle after the strobe.
  task automatic xfer(input logic [3:0] req, input logic [7:0] pat, input int n,
                      input bit hold, input logic [3:0] egnt, input logic ep,
                      input logic ef, input logic [1:0] elen, input int elat);
    exp_t e;
    bit   got;
    bit   done_seen;
    e.gnt = egnt; e.pass = ep; e.fail = ef; e.len = elen; e.lat = elat;
    exp_q.push_back(e);
    req_i = req;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = tx_o;
    end
    if (!got) begin
      check("tx_timeout", 32'd0, 32'd1);
      req_i = '0;
      return;
    end
    done_seen = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (done_o) begin
        done_seen = 1'b1;
        if (!hold) req_i = '0;
      end
      rx_i = (i < n) ? pat[i] : 1'b0;
      if (done_seen && i >= n) break;
    end
    if (!done_seen) check("done_timeout", 32'd0, 32'd1);
    rx_i = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("reset_outputs",
          {21'd0, gnt_o, tx_o, busy_o, done_o, pass_o, fail_o, burst_len_o}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: two highs then low -> pass, len 2
    xfer(4'b0001, 8'b0000_0011, 3, 1'b0, 4'b0001, 1'b1, 1'b0, 2'd2, 4);
    // 2: five highs -> closes at 3, remaining highs ignored
    xfer(4'b0001, 8'b0001_1111, 5, 1'b0, 4'b0001, 1'b1, 1'b0, 2'd3, 4);
    // 3: low at first sample -> fail len 0; one high -> fail len 1
    xfer(4'b0010, 8'b0000_0000, 1, 1'b0, 4'b0010, 1'b0, 1'b1, 2'd0, 2);
    xfer(4'b0010, 8'b0000_0001, 2, 1'b0, 4'b0010, 1'b0, 1'b1, 2'd1, 3);
    // 5: pointer now 2, req 0011 wraps to 0001, then 0010
    xfer(4'b0011, 8'b0000_0011, 3, 1'b1, 4'b0001, 1'b1, 1'b0, 2'd2, 4);
    xfer(4'b0011, 8'b0000_0011, 3, 1'b0, 4'b0010, 1'b1, 1'b0, 2'd2, 4);

    // 4: all four request from pointer 0
    apply_reset();
    xfer(4'b1111, 8'b0000_0011, 3, 1'b1, 4'b0001, 1'b1, 1'b0, 2'd2, 4);
    xfer(4'b1111, 8'b0000_0011, 3, 1'b1, 4'b0010, 1'b1, 1'b0, 2'd2, 4);
    check("tx_gap", tx_gap, 6);
    xfer(4'b1111, 8'b0000_0011, 3, 1'b1, 4'b0100, 1'b1, 1'b0, 2'd2, 4);
    check("tx_gap", tx_gap, 6);
    xfer(4'b1111, 8'b0000_0011, 3, 1'b1, 4'b1000, 1'b1, 1'b0, 2'd2, 4);
    check("tx_gap", tx_gap, 6);
    xfer(4'b1111, 8'b0000_0011, 3, 1'b0, 4'b0001, 1'b1, 1'b0, 2'd2, 4);
    check("tx_gap", tx_gap, 6);

    // 6: reset mid-RX with counter at 1
    req_i = 4'b0010;
    begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        got = tx_o;
      end
      check("rst_tx_seen", {31'd0, got}, 32'd1);
    end
    @(negedge clk);
    rx_i = 1'b1;
    @(negedge clk);
    check("busy_before_reset", {31'd0, busy_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {21'd0, gnt_o, tx_o, busy_o, done_o, pass_o, fail_o, burst_len_o}, 32'd0);
    req_i = '0;
    rx_i  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xfer(4'b0100, 8'b0000_0011, 3, 1'b0, 4'b0100, 1'b1, 1'b0, 2'd2, 4);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, time %0t limit 100000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
